imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbiter and sequencer for the byte-addressed instruction memory. It shares the single memory port between the core fetch stage (word reads) and the program loader (byte reads and writes). It range-checks every access and returns registered responses one cycle after grant. It sits between the fetch stage/loader and the `instr_memory` storage array, which it drives through a raw port.

## Interface
- `NUM_INSTR`, 32, memory depth in 32-bit instructions; byte count `NB = NUM_INSTR*4`, memory address width `AW = $clog2(NB)`
- `NOP_INSTR`, 32'h0000_0013, word returned on a faulted fetch
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `load_mode` in 1 — 1: loader has absolute priority; 0: round-robin
- `fetch_req` in 1 — fetch wants a word
- `fetch_addr` in 32 — byte address of the word
- `fetch_gnt` out 1 — fetch accepted this cycle (combinational)
- `fetch_rvalid` out 1 — fetch response valid (one-cycle pulse)
- `fetch_rdata` out 32 — fetched word, MSB = byte at `addr`
- `fetch_err` out 1 — qualifies `fetch_rvalid`; the access faulted
- `ld_req` in 1 — loader access request
- `ld_we` in 1 — 1 = byte write, 0 = byte read
- `ld_addr` in 32 — loader byte address
- `ld_wdata` in 8 — write byte
- `ld_gnt` out 1 — loader accepted this cycle (combinational)
- `ld_rvalid` out 1 — loader response valid (one-cycle pulse, reads and writes)
- `ld_rdata` out 8 — read byte
- `ld_err` out 1 — qualifies `ld_rvalid`; out-of-range access
- `mem_we` out 1 — byte write strobe to the storage array
- `mem_addr` out AW — byte address to the storage array
- `mem_wdata` out 8 — write byte to the storage array
- `mem_rdata` in 32 — combinational word `{mem[a],mem[a+1],mem[a+2],mem[a+3]}`
- `fetch_stall_cnt` out 16 — saturating count of cycles with `fetch_req` high and `fetch_gnt` low

## Operation
- **Grant rules (combinational, at most one grant per cycle):**
  - If only one requester is active, it is granted.
  - If both are active and `load_mode`=1, the loader is granted.
  - If both are active and `load_mode`=0, the requester not in `last_gnt` is granted.
  - `last_gnt` updates on every grant. It resets to LOADER, so fetch wins the first tie.
- **Fetch fault:** `fetch_addr[1:0]!=0` or `fetch_addr > NB-4`.
  - The fetch is still granted.
  - `mem_addr` is forced to 0 and `mem_we` stays 0.
  - The response is `fetch_err`=1 with `fetch_rdata`=`NOP_INSTR`.
- **Loader fault:** `ld_addr >= NB`.
  - The loader is granted and the write is suppressed (`mem_we`=0).
  - The response is `ld_err`=1 with `ld_rdata`=0.
- **Memory port drive:**
  - `mem_addr` = granted address[AW-1:0] (0 when idle or faulted).
  - `mem_we` = `ld_gnt & ld_we & ~fault`.
  - `mem_wdata` = `ld_wdata`.
- **Response capture:** in the grant cycle, the arbiter registers `mem_rdata` (fetch) or `mem_rdata[31:24]` (loader read).
  - A loader write response carries `ld_rdata`=0.
- **Response hold:** `fetch_rdata` and `ld_rdata` hold their last response until the next response on that side.
- **Response FSM:** one register per side, states `IDLE` and `RESP`.
  - A grant moves the side to `RESP` for exactly one cycle.
  - The side returns to `IDLE` unless it is granted again. Back-to-back grants give back-to-back `rvalid`.
- **Stall counter:** `fetch_stall_cnt` increments each cycle with `fetch_req & ~fetch_gnt` and saturates at 16'hFFFF.
  - It does not clear on grant; only reset clears it.

## Timing
- **Reset values:**
  - `fetch_rvalid`=0, `fetch_err`=0, `fetch_rdata`=0
  - `ld_rvalid`=0, `ld_err`=0, `ld_rdata`=0
  - `fetch_stall_cnt`=0, `last_gnt`=LOADER, both FSMs `IDLE`
  - Grants and `mem_*` are combinational. They are 0 while no request is present.
- **Latency:** a request granted at edge-cycle N produces its `rvalid` in cycle N+1. Throughput is one access per cycle.
- **Read-after-write:** a loader write at cycle N is visible to a fetch granted at cycle N+1.
- **Request hold:** a requester must hold `req` and its address until it sees `gnt`. Dropping `req` before grant is legal, and the request is lost.
- **Reset mid-operation:** asserting `rst` clears pending `rvalid` immediately (asynchronously) and drops the in-flight response. The first grant after deassertion follows the reset `last_gnt` rule.
- **Mode change:** changing `load_mode` affects arbitration in the same cycle. It has no effect on responses already in flight.

## Test plan
- **Reset and single fetch:** release reset, preload `mem` bytes 0..3 = 13 00 00 00, fetch addr 0 → `fetch_gnt`=1, next cycle `fetch_rvalid`=1, `fetch_rdata`=32'h1300_0000, `fetch_err`=0.
- **Round-robin tie:** `load_mode`=0, both requesting continuously for 4 cycles → grants alternate F,L,F,L; `fetch_stall_cnt`=2.
- **Loader priority:** `load_mode`=1, both requesting for 3 cycles → 3 loader grants; `fetch_stall_cnt`=3; then drop `ld_req` → fetch granted next cycle.
- **Write-then-fetch:** loader writes AA,BB,CC,DD to bytes 8..11, then fetch 8 → `fetch_rdata`=32'hAABB_CCDD one cycle after grant.
- **Faults:** fetch addr 2 → `fetch_err`=1, `fetch_rdata`=32'h0000_0013, `mem_we`=0. Fetch addr `NB-2` → `fetch_err`=1. Loader write to addr `NB` → `ld_err`=1, memory contents unchanged.
- **Reset mid-response:** assert `rst` in the cycle after a grant → `fetch_rvalid` drops to 0 immediately; after release, the first tie grants fetch.

Source files
------------

// File: rtl/imem_arbiter.sv
// Shares the single byte-addressed instruction-memory port between the fetch stage
// (word reads) and the program loader (byte reads/writes), with registered responses.
module imem_arbiter #(
  parameter int          NUM_INSTR = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int         NB        = NUM_INSTR * 4,
  localparam int         AW        = $clog2(NB)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_mode,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [7:0]    ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [7:0]    ld_rdata,
  output logic          ld_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   fetch_stall_cnt
);

  typedef enum logic { S_IDLE, S_RESP } resp_state_t;
  typedef enum logic { GNT_FETCH, GNT_LOADER } gnt_side_t;

  localparam logic [31:0] NB32      = 32'(NB);
  localparam logic [31:0] FETCH_MAX = 32'(NB - 4);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  resp_state_t   r_f_state;
  resp_state_t   r_l_state;
  gnt_side_t     r_last_gnt;
  logic [31:0]   r_fetch_rdata;
  logic          r_fetch_err;
  logic [7:0]    r_ld_rdata;
  logic          r_ld_err;
  logic [15:0]   r_stall_cnt;

  logic          w_f_fault;
  logic          w_l_fault;
  logic          w_fetch_gnt;
  logic          w_ld_gnt;
  logic [AW-1:0] w_mem_addr;

  assign w_f_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr > FETCH_MAX);
  assign w_l_fault = (ld_addr >= NB32);

  // On a tie the side that did not win last time gets the port, unless the loader owns it.
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_ld_gnt    = 1'b0;
    if (fetch_req && ld_req) begin
      if (load_mode || (r_last_gnt == GNT_FETCH)) w_ld_gnt = 1'b1;
      else                                        w_fetch_gnt = 1'b1;
    end else begin
      w_fetch_gnt = fetch_req;
      w_ld_gnt    = ld_req;
    end
  end

  always_comb begin
    w_mem_addr = '0;
    if (w_fetch_gnt && !w_f_fault)   w_mem_addr = fetch_addr[AW-1:0];
    else if (w_ld_gnt && !w_l_fault) w_mem_addr = ld_addr[AW-1:0];
  end

  assign fetch_gnt = w_fetch_gnt;
  assign ld_gnt    = w_ld_gnt;
  assign mem_addr  = w_mem_addr;
  assign mem_we    = w_ld_gnt & ld_we & ~w_l_fault;
  assign mem_wdata = ld_req ? ld_wdata : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt  <= GNT_LOADER;
      r_stall_cnt <= 16'h0000;
    end else begin
      if (w_fetch_gnt)   r_last_gnt <= GNT_FETCH;
      else if (w_ld_gnt) r_last_gnt <= GNT_LOADER;
      if (fetch_req && !w_fetch_gnt) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  // Fetch response: data holds between responses, err only accompanies rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_state     <= S_IDLE;
      r_fetch_err   <= 1'b0;
      r_fetch_rdata <= 32'h0;
    end else begin
      case (r_f_state)
        S_IDLE, S_RESP: begin
          if (w_fetch_gnt) begin
            r_f_state     <= S_RESP;
            r_fetch_err   <= w_f_fault;
            r_fetch_rdata <= w_f_fault ? NOP_INSTR : mem_rdata;
          end else begin
            r_f_state   <= S_IDLE;
            r_fetch_err <= 1'b0;
          end
        end
        default: r_f_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l_state  <= S_IDLE;
      r_ld_err   <= 1'b0;
      r_ld_rdata <= 8'h00;
    end else begin
      case (r_l_state)
        S_IDLE, S_RESP: begin
          if (w_ld_gnt) begin
            r_l_state  <= S_RESP;
            r_ld_err   <= w_l_fault;
            r_ld_rdata <= (w_l_fault || ld_we) ? 8'h00 : mem_rdata[31:24];
          end else begin
            r_l_state <= S_IDLE;
            r_ld_err  <= 1'b0;
          end
        end
        default: r_l_state <= S_IDLE;
      endcase
    end
  end

  assign fetch_rvalid    = (r_f_state == S_RESP);
  assign fetch_err       = r_fetch_err;
  assign fetch_rdata     = r_fetch_rdata;
  assign ld_rvalid       = (r_l_state == S_RESP);
  assign ld_err          = r_ld_err;
  assign ld_rdata        = r_ld_rdata;
  assign fetch_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: byte-array storage model on the raw port, directed scenarios
// and randomized traffic checked against a transaction-level reference model.
module tb_imem_arbiter;
  localparam int          NUM_INSTR = 32;
  localparam int          NB        = NUM_INSTR * 4;
  localparam int          AW        = $clog2(NB);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic          clk, rst, load_mode;
  logic          fetch_req, fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0]   fetch_addr, fetch_rdata;
  logic          ld_req, ld_we, ld_gnt, ld_rvalid, ld_err;
  logic [31:0]   ld_addr;
  logic [7:0]    ld_wdata, ld_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   fetch_stall_cnt;

  imem_arbiter #(.NUM_INSTR(NUM_INSTR), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .load_mode(load_mode),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fetch_stall_cnt(fetch_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array attached to the raw port.
  logic       tb_clr;
  logic [7:0] tb_mem [NB];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int k = 0; k < NB; k++) tb_mem[k] <= 8'h00;
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    int idx;
    mem_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      idx = int'(mem_addr) + k;
      mem_rdata[31-8*k -: 8] = (idx < NB) ? tb_mem[idx[AW-1:0]] : 8'h00;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  ref_mem [NB];
  bit          m_last_ld;
  int          m_stall;
  bit          e_fv, e_fe, e_lv, e_le;
  logic [31:0] e_fd;
  logic [7:0]  e_ld;
  bit          m_gf, m_gl;
  bit          obs_fg, obs_lg, obs_mwe;

  task automatic model_reset();
    m_last_ld = 1'b1;
    m_stall   = 0;
    e_fv = 0; e_fe = 0; e_fd = 32'h0;
    e_lv = 0; e_le = 0; e_ld = 8'h00;
  endtask

  task automatic step(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                      input logic [31:0] la, input logic [7:0] lwd, input bit mode);
    bit ff, lf;
    logic [31:0] ea;
    logic [AW-1:0] a;
    fetch_req = fr; fetch_addr = fa;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd;
    load_mode = mode;
    #1;
    ff = (fa[1:0] != 2'b00) || (fa > 32'(NB - 4));
    lf = (la >= 32'(NB));
    if (fr && lr) begin
      m_gl = mode || !m_last_ld;
      m_gf = !m_gl;
    end else begin
      m_gf = fr;
      m_gl = lr;
    end
    ea = 32'h0;
    if (m_gf && !ff)      ea = {{(32-AW){1'b0}}, fa[AW-1:0]};
    else if (m_gl && !lf) ea = {{(32-AW){1'b0}}, la[AW-1:0]};
    obs_fg = fetch_gnt; obs_lg = ld_gnt; obs_mwe = mem_we;
    chk("fetch_gnt", {31'b0, fetch_gnt}, {31'b0, m_gf});
    chk("ld_gnt", {31'b0, ld_gnt}, {31'b0, m_gl});
    chk("mem_we", {31'b0, mem_we}, {31'b0, (m_gl && lw && !lf)});
    chk("mem_addr", 32'(mem_addr), ea);
    if (lr) chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, lwd});
    if (m_gf) begin
      a = fa[AW-1:0];
      e_fe = ff;
      e_fd = ff ? NOP : {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    end
    e_fv = m_gf;
    if (m_gl) begin
      a = la[AW-1:0];
      e_le = lf;
      e_ld = (lf || lw) ? 8'h00 : ref_mem[a];
      if (lw && !lf) ref_mem[a] = lwd;
    end
    e_lv = m_gl;
    if (m_gf)      m_last_ld = 1'b0;
    else if (m_gl) m_last_ld = 1'b1;
    if (fr && !m_gf && m_stall < 65535) m_stall++;
    @(posedge clk); #1;
    chk("fetch_rvalid", {31'b0, fetch_rvalid}, {31'b0, e_fv});
    if (e_fv) chk("fetch_err", {31'b0, fetch_err}, {31'b0, e_fe});
    chk("fetch_rdata", fetch_rdata, e_fd);
    chk("ld_rvalid", {31'b0, ld_rvalid}, {31'b0, e_lv});
    if (e_lv) chk("ld_err", {31'b0, ld_err}, {31'b0, e_le});
    chk("ld_rdata", {24'b0, ld_rdata}, {24'b0, e_ld});
    chk("stall_cnt", {16'b0, fetch_stall_cnt}, 32'(m_stall));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_req = 0; fetch_addr = 0; ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    load_mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_rvalid", {31'b0, fetch_rvalid}, 32'h0);
    chk("rst_fetch_rdata", fetch_rdata, 32'h0);
    chk("rst_ld_rvalid", {31'b0, ld_rvalid}, 32'h0);
    chk("rst_ld_rdata", {24'b0, ld_rdata}, 32'h0);
    chk("rst_stall", {16'b0, fetch_stall_cnt}, 32'h0);
    chk("rst_gnts", {30'b0, fetch_gnt, ld_gnt}, 32'h0);
    chk("rst_mem", {24'b0, mem_we, mem_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    bit fr, lr, lw, mode;
    logic [31:0] fa, la;
    logic [7:0] lwd;
    tb_clr = 1'b1;
    for (int k = 0; k < NB; k++) ref_mem[k] = 8'h00;
    do_reset();
    tb_clr = 1'b0;

    // Preload bytes 0..3 then fetch word 0
    step(0, 0, 1, 1, 32'd0, 8'h13, 0);
    for (int k = 1; k < 4; k++) step(0, 0, 1, 1, 32'(k), 8'h00, 0);
    step(1, 32'd0, 0, 0, 0, 0, 0);
    chk("single_rvalid", {31'b0, fetch_rvalid}, 32'h1);
    chk("single_rdata", fetch_rdata, 32'h1300_0000);
    chk("single_err", {31'b0, fetch_err}, 32'h0);

    // Round-robin tie from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 32'd0, 1, 0, 32'd1, 8'h00, 0);
      chk("rr_fetch_gnt", {31'b0, obs_fg}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    chk("rr_stall", {16'b0, fetch_stall_cnt}, 32'd2);

    // Loader priority
    s0 = int'(fetch_stall_cnt);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'd4, 1, 0, 32'd2, 8'h00, 1);
      chk("prio_ld_gnt", {31'b0, obs_lg}, 32'h1);
    end
    chk("prio_stall", {16'b0, fetch_stall_cnt}, 32'(s0 + 3));
    step(1, 32'd4, 0, 0, 32'd2, 8'h00, 1);
    chk("prio_fetch_after_drop", {31'b0, obs_fg}, 32'h1);

    // Write then fetch
    step(0, 0, 1, 1, 32'd8,  8'hAA, 0);
    step(0, 0, 1, 1, 32'd9,  8'hBB, 0);
    step(0, 0, 1, 1, 32'd10, 8'hCC, 0);
    step(0, 0, 1, 1, 32'd11, 8'hDD, 0);
    step(1, 32'd8, 0, 0, 0, 0, 0);
    chk("raw_rdata", fetch_rdata, 32'hAABB_CCDD);

    // Faults
    step(1, 32'd2, 0, 0, 0, 0, 0);
    chk("fault_mis_err", {31'b0, fetch_err}, 32'h1);
    chk("fault_mis_rdata", fetch_rdata, 32'h0000_0013);
    chk("fault_mis_we", {31'b0, obs_mwe}, 32'h0);
    step(1, 32'(NB - 2), 0, 0, 0, 0, 0);
    chk("fault_top_err", {31'b0, fetch_err}, 32'h1);
    step(0, 0, 1, 1, 32'(NB), 8'h5A, 0);
    chk("fault_ld_err", {31'b0, ld_err}, 32'h1);
    chk("fault_ld_we", {31'b0, obs_mwe}, 32'h0);
    step(0, 0, 1, 0, 32'd0, 8'h00, 0);
    chk("fault_mem_kept", {24'b0, ld_rdata}, 32'h13);
    step(1, 32'(NB - 4), 0, 0, 0, 0, 0);
    chk("fetch_top_ok_err", {31'b0, fetch_err}, 32'h0);

    // Reset in the response cycle
    step(1, 32'd0, 0, 0, 0, 0, 0);
    chk("midrst_pre_rvalid", {31'b0, fetch_rvalid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", {31'b0, fetch_rvalid}, 32'h0);
    model_reset();
    fetch_req = 0; ld_req = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    step(1, 32'd8, 1, 0, 32'd3, 8'h00, 0);
    chk("midrst_tie_fetch", {31'b0, obs_fg}, 32'h1);

    // Randomized traffic honouring the request-hold rule
    fr = 0; lr = 0; lw = 0; fa = 0; la = 0; lwd = 0; mode = 0;
    for (int i = 0; i < 800; i++) begin
      if (!fr || $urandom_range(9) == 0) begin
        fr = ($urandom_range(3) != 0);
        if ($urandom_range(5) == 0) fa = 32'($urandom_range(NB + 8));
        else                        fa = 32'($urandom_range(NB / 4 - 1) * 4);
      end
      if (!lr || $urandom_range(9) == 0) begin
        lr  = ($urandom_range(2) != 0);
        lw  = $urandom_range(1) == 1;
        la  = ($urandom_range(7) == 0) ? 32'($urandom_range(NB + 4)) : 32'($urandom_range(NB - 1));
        lwd = 8'($urandom_range(255));
      end
      if ($urandom_range(7) == 0) mode = ~mode;
      step(fr, fa, lr, lw, la, lwd, mode);
      if (m_gf) fr = 0;
      if (m_gl) lr = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
